// File: rtl/spgd_iter_sequencer_pkg.sv
// SPGD iteration sequencer shared definitions.
// State encoding, LFSR seed and LFSR step.
package spgd_iter_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SET_P,
        S_SETTLE_P,
        S_MEAS_P,
        S_SET_M,
        S_SETTLE_M,
        S_MEAS_M,
        S_UPDATE
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // x^16+x^14+x^13+x^11+1, right-shifting Fibonacci form
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    endfunction

endpackage

// File: rtl/spgd_sat_addsub.sv
// Unsigned DAC code plus/minus a signed offset.
// Computed at full width, then clamped to [0, 2^DW-1].
module spgd_sat_addsub #(
    parameter int DW = 14,
    parameter int OW = 25
) (
    input  logic [DW-1:0]        code,
    input  logic signed [OW-1:0] offset,
    input  logic                 neg,
    output logic [DW-1:0]        result
);

    localparam int W = ((OW > DW) ? OW : DW) + 2;

    logic signed [W-1:0] base;
    logic signed [W-1:0] off;
    logic signed [W-1:0] sum;

    assign base = $signed({{(W-DW){1'b0}}, code});
    assign off  = {{(W-OW){offset[OW-1]}}, offset};
    assign sum  = neg ? (base - off) : (base + off);

    // clamp: negative -> 0, above code range -> all ones
    always_comb begin
        if (sum[W-1]) begin
            result = '0;
        end else if (|sum[W-2:DW]) begin
            result = '1;
        end else begin
            result = sum[DW-1:0];
        end
    end

endmodule

// File: rtl/spgd_iter_sequencer.sv
// SPGD iteration sequencer: dither both DACs +/-, average
// the metric for each sign, then step the controls.
module spgd_iter_sequencer
    import spgd_iter_sequencer_pkg::*;
#(
    parameter int DAC_WIDTH     = 14,
    parameter int METRIC_WIDTH  = 24,
    parameter int SETTLE_CYCLES = 64,
    parameter int TIMEOUT       = 8192
) (
    input  logic                    ADC_CLK,
    input  logic                    RST_N,
    input  logic                    EN,
    input  logic [DAC_WIDTH-3:0]    DITHER_AMP,
    input  logic [3:0]              GAIN_SHIFT,
    output logic                    AVG_START,
    input  logic                    AVG_DONE,
    input  logic [METRIC_WIDTH-1:0] AVG_SUM,
    output logic [DAC_WIDTH-1:0]    DACA_CODE_OUT,
    output logic [DAC_WIDTH-1:0]    DACB_CODE_OUT,
    output logic                    BUSY,
    output logic [15:0]             ITER_COUNT,
    output logic                    TIMEOUT_ERR
);

    localparam int CNT_MAX =
        (TIMEOUT > SETTLE_CYCLES) ? TIMEOUT : SETTLE_CYCLES;
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TIMEOUT - 1);

    localparam logic [DAC_WIDTH-1:0] MID =
        {1'b1, {(DAC_WIDTH-1){1'b0}}};

    state_t                  state;
    logic [DAC_WIDTH-1:0]    ua;
    logic [DAC_WIDTH-1:0]    ub;
    logic [METRIC_WIDTH-1:0] jp;
    logic [METRIC_WIDTH-1:0] jm;
    logic [DAC_WIDTH-3:0]    amp;
    logic [3:0]              gsh;
    logic [15:0]             lfsr;
    logic [CNT_W-1:0]        cnt;

    logic                        sa;
    logic                        sb;
    logic                        dith_sub;
    logic signed [DAC_WIDTH-2:0] dith_off;
    logic [DAC_WIDTH-1:0]        dith_a;
    logic [DAC_WIDTH-1:0]        dith_b;
    logic signed [METRIC_WIDTH:0] dj;
    logic signed [METRIC_WIDTH:0] step;
    logic [DAC_WIDTH-1:0]        upd_a;
    logic [DAC_WIDTH-1:0]        upd_b;
    logic                        abort;

    assign sa       = lfsr[0];
    assign sb       = lfsr[1];
    assign dith_sub = (state == S_SET_M);
    assign dith_off = {1'b0, amp};
    assign dj       = $signed({1'b0, jp}) - $signed({1'b0, jm});
    assign step     = dj >>> gsh;
    assign BUSY     = (state != S_IDLE);
    assign abort    = !EN && (state != S_IDLE) && (state != S_UPDATE);

    spgd_sat_addsub #(.DW(DAC_WIDTH), .OW(DAC_WIDTH-1)) u_dith_a (
        .code   (ua),
        .offset (dith_off),
        .neg    (dith_sub ? sa : ~sa),
        .result (dith_a)
    );

    spgd_sat_addsub #(.DW(DAC_WIDTH), .OW(DAC_WIDTH-1)) u_dith_b (
        .code   (ub),
        .offset (dith_off),
        .neg    (dith_sub ? sb : ~sb),
        .result (dith_b)
    );

    spgd_sat_addsub #(.DW(DAC_WIDTH), .OW(METRIC_WIDTH+1)) u_upd_a (
        .code   (ua),
        .offset (step),
        .neg    (~sa),
        .result (upd_a)
    );

    spgd_sat_addsub #(.DW(DAC_WIDTH), .OW(METRIC_WIDTH+1)) u_upd_b (
        .code   (ub),
        .offset (step),
        .neg    (~sb),
        .result (upd_b)
    );

    // iteration FSM with settle/timeout counter and registered outputs
    always_ff @(posedge ADC_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state         <= S_IDLE;
            ua            <= MID;
            ub            <= MID;
            DACA_CODE_OUT <= MID;
            DACB_CODE_OUT <= MID;
            jp            <= '0;
            jm            <= '0;
            amp           <= '0;
            gsh           <= '0;
            lfsr          <= LFSR_SEED;
            cnt           <= '0;
            AVG_START     <= 1'b0;
            ITER_COUNT    <= '0;
            TIMEOUT_ERR   <= 1'b0;
        end else begin
            AVG_START <= 1'b0;
            if (abort) begin
                // EN dropped: discard the iteration, any AVG_DONE included
                state         <= S_IDLE;
                DACA_CODE_OUT <= ua;
                DACB_CODE_OUT <= ub;
                cnt           <= '0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        amp <= DITHER_AMP;
                        gsh <= GAIN_SHIFT;
                        cnt <= '0;
                        if (EN) begin
                            state <= S_SET_P;
                        end
                    end
                    S_SET_P, S_SET_M: begin
                        DACA_CODE_OUT <= dith_a;
                        DACB_CODE_OUT <= dith_b;
                        cnt           <= '0;
                        state         <= dith_sub ? S_SETTLE_M : S_SETTLE_P;
                    end
                    S_SETTLE_P, S_SETTLE_M: begin
                        if (cnt == SETTLE_LAST) begin
                            cnt       <= '0;
                            AVG_START <= 1'b1;
                            state     <= (state == S_SETTLE_P) ? S_MEAS_P
                                                               : S_MEAS_M;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_MEAS_P, S_MEAS_M: begin
                        if (AVG_DONE) begin
                            cnt <= '0;
                            if (state == S_MEAS_P) begin
                                jp    <= AVG_SUM;
                                state <= S_SET_M;
                            end else begin
                                jm    <= AVG_SUM;
                                state <= S_UPDATE;
                            end
                        end else if (cnt == TMO_LAST) begin
                            TIMEOUT_ERR   <= 1'b1;
                            DACA_CODE_OUT <= ua;
                            DACB_CODE_OUT <= ub;
                            cnt           <= '0;
                            state         <= S_IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_UPDATE: begin
                        ua            <= upd_a;
                        ub            <= upd_b;
                        DACA_CODE_OUT <= upd_a;
                        DACB_CODE_OUT <= upd_b;
                        ITER_COUNT    <= ITER_COUNT + 16'd1;
                        lfsr          <= lfsr_step(lfsr);
                        amp           <= DITHER_AMP;
                        gsh           <= GAIN_SHIFT;
                        cnt           <= '0;
                        state         <= EN ? S_SET_P : S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
